// File: rtl/mc_core.sv
// mc_core: multi-cycle load/store core, 8 x DW registers, 16-bit instructions,
// one shared memory port completed by the mem_req & mem_rdy handshake.
module mc_core #(
    parameter int unsigned DW     = 16,
    parameter int unsigned AW     = 8,
    parameter int unsigned RST_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_on,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic [DW-1:0] out_r,
    output logic          out_vld,
    output logic [AW-1:0] pc,
    output logic [3:0]    flags,
    output logic          halted
);
    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StHalt} state_e;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpOr   = 4'h3;
    localparam logic [3:0] OpLdi  = 4'h4;
    localparam logic [3:0] OpLd   = 4'h5;
    localparam logic [3:0] OpSt   = 4'h6;
    localparam logic [3:0] OpJmp  = 4'h7;
    localparam logic [3:0] OpBz   = 4'h8;
    localparam logic [3:0] OpOut  = 4'h9;
    localparam logic [3:0] OpHalt = 4'hF;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [DW-1:0] rf_q [8];
    logic [DW-1:0] rf_d [8];
    logic [3:0]    flags_q, flags_d;
    logic [DW-1:0] out_q, out_d;
    logic          out_vld_q, out_vld_d;
    logic          fetch_pend_q, fetch_pend_d;

    logic [3:0]    op;
    logic [2:0]    rd, ra, rb;
    logic [7:0]    imm8;
    logic [AW-1:0] bz_off;
    logic          unused_ir11;

    assign op          = ir_q[15:12];
    assign rd          = ir_q[10:8];
    assign ra          = ir_q[7:5];
    assign rb          = ir_q[4:2];
    assign imm8        = ir_q[7:0];
    assign unused_ir11 = ir_q[11];
    assign bz_off      = AW'({{56{imm8[7]}}, imm8});

    logic [DW:0]   add_full, sub_full;
    logic [DW-1:0] alu_res;
    logic          alu_c, alu_v;

    // Logic ops clear carry as well as overflow.
    always_comb begin
        add_full = {1'b0, a_q} + {1'b0, b_q};
        sub_full = {1'b0, a_q} - {1'b0, b_q};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (op[1:0])
            2'd0: begin
                alu_res = add_full[DW-1:0];
                alu_c   = add_full[DW];
                alu_v   = (a_q[DW-1] == b_q[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            2'd1: begin
                alu_res = sub_full[DW-1:0];
                alu_c   = ~sub_full[DW];
                alu_v   = (a_q[DW-1] != b_q[DW-1]) && (alu_res[DW-1] != a_q[DW-1]);
            end
            2'd2:    alu_res = a_q & b_q;
            default: alu_res = a_q | b_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        rf_d         = rf_q;
        flags_d      = flags_q;
        out_d        = out_q;
        out_vld_d    = 1'b0;
        fetch_pend_d = fetch_pend_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = pc_q;
        mem_wdata    = b_q;
        unique case (state_q)
            StFetch: begin
                // A started fetch keeps requesting even if cpu_on drops meanwhile.
                mem_req = (cpu_on | fetch_pend_q) & ~rst;
                if (mem_req && mem_rdy) begin
                    ir_d         = mem_rdata[15:0];
                    pc_d         = pc_q + AW'(1);
                    fetch_pend_d = 1'b0;
                    state_d      = StDecode;
                end else begin
                    fetch_pend_d = mem_req;
                end
            end
            StDecode: begin
                a_d     = rf_q[ra];
                b_d     = rf_q[rb];
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OpAdd, OpSub, OpAnd, OpOr: begin
                        rf_d[rd] = alu_res;
                        flags_d  = {alu_res[DW-1], alu_res == '0, alu_c, alu_v};
                    end
                    OpLdi:       rf_d[rd] = DW'(imm8);
                    OpLd, OpSt:  state_d = StMem;
                    OpJmp:       pc_d = a_q[AW-1:0];
                    OpBz:        if (flags_q[2]) pc_d = pc_q + bz_off;
                    OpOut: begin
                        out_d     = a_q;
                        out_vld_d = 1'b1;
                    end
                    OpHalt:      state_d = StHalt;
                    default:     ;
                endcase
            end
            StMem: begin
                mem_req  = ~rst;
                mem_we   = (op == OpSt) & ~rst;
                mem_addr = a_q[AW-1:0];
                if (mem_req && mem_rdy) begin
                    if (op == OpLd) rf_d[rd] = mem_rdata;
                    state_d = StFetch;
                end
            end
            StHalt:  ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= AW'(RST_PC);
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            flags_q      <= '0;
            out_q        <= '0;
            out_vld_q    <= 1'b0;
            fetch_pend_q <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            a_q          <= a_d;
            b_q          <= b_d;
            flags_q      <= flags_d;
            out_q        <= out_d;
            out_vld_q    <= out_vld_d;
            fetch_pend_q <= fetch_pend_d;
            rf_q         <= rf_d;
        end
    end

    assign pc      = pc_q;
    assign flags   = flags_q;
    assign out_r   = out_q;
    assign out_vld = out_vld_q;
    assign halted  = (state_q == StHalt);
endmodule

// File: tb/tb_mc_core.sv
// tb_mc_core: directed and random programs checked against an instruction-level
// model of the core that also predicts cycle timing from the mem_rdy pattern.
module tb_mc_core;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int RST_PC = 0;
    localparam int RDY_LEN = 4096;

    logic          clk = 1'b0;
    logic          rst, cpu_on, mem_req, mem_we, mem_rdy, out_vld, halted;
    logic [7:0]    mem_addr, pc;
    logic [15:0]   mem_wdata, mem_rdata, out_r;
    logic [3:0]    flags;
    logic [15:0]   tb_mem [256];

    assign mem_rdata = tb_mem[mem_addr];
    always #5 clk = ~clk;

    mc_core #(.DW(DW), .AW(AW), .RST_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .cpu_on(cpu_on), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rdy(mem_rdy), .out_r(out_r), .out_vld(out_vld), .pc(pc), .flags(flags),
        .halted(halted)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level model
    logic [15:0] m_r [8];
    logic [15:0] m_mem [256];
    logic [7:0]  m_pc;
    logic [3:0]  m_flags;
    logic [15:0] m_out;
    bit          m_halt;
    bit          rdy_arr [RDY_LEN];
    int          exp_cyc [$];
    logic [15:0] exp_val [$];

    function automatic bit rdy_at(input int c);
        return (c < RDY_LEN) ? rdy_arr[c] : 1'b1;
    endfunction

    function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
        return {4'(op), 1'b0, 3'(rd), 3'(ra), 3'(rb), 2'b00};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int imm);
        return {4'(op), 1'b0, 3'(rd), 8'(imm)};
    endfunction

    task automatic set_rdy_all(input bit v);
        for (int i = 0; i < RDY_LEN; i++) rdy_arr[i] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = tb_mem[i];
        m_pc = 8'(RST_PC);
        m_flags = '0;
        m_out = '0;
        m_halt = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) tb_mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cpu_on = 1'b0; mem_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one cycle's inputs and plays the memory side of any completing store.
    task automatic drive(input bit on, input bit rdy);
        cpu_on = on; mem_rdy = rdy;
        #1;
        if (mem_req && mem_we && mem_rdy) tb_mem[mem_addr] = mem_wdata;
    endtask

    task automatic run_program(input string tag, input int n_ins);
        int t = 0;
        int u, s, off;
        logic [15:0] ins, va, vb, res;
        logic [3:0] op;
        bit c_f, v_f, prev_wait, ev;
        logic [7:0] p_addr;
        logic [15:0] p_wdata;
        logic p_we;
        int mism;
        exp_cyc.delete();
        exp_val.delete();
        for (int i = 0; i < n_ins && !m_halt; i++) begin
            while (!rdy_at(t)) t++;
            ins = m_mem[m_pc];
            m_pc = m_pc + 8'd1;
            t += 2;
            op = ins[15:12];
            va = m_r[ins[7:5]];
            vb = m_r[ins[4:2]];
            if (op <= 4'h3) begin
                c_f = 1'b0; v_f = 1'b0;
                case (op)
                    4'h0: begin
                        u = int'(va) + int'(vb); s = int'($signed(va)) + int'($signed(vb));
                        res = 16'(u); c_f = (u > 65535); v_f = (s > 32767) || (s < -32768);
                    end
                    4'h1: begin
                        u = int'(va) - int'(vb); s = int'($signed(va)) - int'($signed(vb));
                        res = 16'(u); c_f = (va >= vb); v_f = (s > 32767) || (s < -32768);
                    end
                    4'h2: res = va & vb;
                    default: res = va | vb;
                endcase
                m_r[ins[10:8]] = res;
                m_flags = {res[15], res == 16'h0, c_f, v_f};
            end else if (op == 4'h4) begin
                m_r[ins[10:8]] = {8'h00, ins[7:0]};
            end else if (op == 4'h7) begin
                m_pc = va[7:0];
            end else if (op == 4'h8) begin
                off = (ins[7:0] >= 8'd128) ? int'(ins[7:0]) - 256 : int'(ins[7:0]);
                if (m_flags[2]) m_pc = 8'(int'(m_pc) + off);
            end else if (op == 4'h9) begin
                m_out = va;
                exp_cyc.push_back(t + 1);
                exp_val.push_back(va);
            end else if (op == 4'hF) begin
                m_halt = 1'b1;
            end
            t += 1;
            if (op == 4'h5 || op == 4'h6) begin
                while (!rdy_at(t)) t++;
                if (op == 4'h5) m_r[ins[10:8]] = m_mem[va[7:0]];
                else m_mem[va[7:0]] = vb;
                t += 1;
            end
        end

        prev_wait = 1'b0;
        p_addr = '0; p_wdata = '0; p_we = 1'b0;
        for (int c = 0; c <= t + 3; c++) begin
            drive(c < t, rdy_at(c));
            if (prev_wait) begin
                chk({tag, " hold req"}, mem_req, 1'b1);
                chk({tag, " hold addr"}, mem_addr, p_addr);
                chk({tag, " hold we"}, mem_we, p_we);
                if (p_we) chk({tag, " hold wdata"}, mem_wdata, p_wdata);
            end
            ev = (exp_cyc.size() > 0) && (exp_cyc[0] == c);
            chk($sformatf("%s out_vld@%0d", tag, c), out_vld, ev);
            if (ev) begin
                chk($sformatf("%s out_r@%0d", tag, c), out_r, exp_val[0]);
                void'(exp_cyc.pop_front());
                void'(exp_val.pop_front());
            end
            if (c == t) begin
                chk({tag, " park pc"}, pc, m_pc);
                chk({tag, " park req"}, mem_req, 1'b0);
                chk({tag, " halted"}, halted, m_halt);
            end
            prev_wait = mem_req && !mem_rdy;
            p_addr = mem_addr; p_wdata = mem_wdata; p_we = mem_we;
            @(negedge clk);
        end
        #1;
        chk({tag, " flags"}, flags, m_flags);
        chk({tag, " out_r"}, out_r, m_out);
        chk({tag, " missing outs"}, exp_cyc.size(), 0);
        mism = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== m_mem[i]) mism++;
        chk({tag, " mem image"}, mism, 0);
    endtask

    initial begin
        rst = 1'b1; cpu_on = 1'b0; mem_rdy = 1'b0;
        clear_mem();
        tb_mem[0] = 16'hF000;
        set_rdy_all(1'b1);
        do_reset();
        #1;
        chk("rst pc", pc, RST_PC);
        chk("rst flags", flags, 4'h0);
        chk("rst out_r", out_r, 16'h0);
        chk("rst out_vld", out_vld, 1'b0);
        chk("rst halted", halted, 1'b0);
        chk("rst mem_req", mem_req, 1'b0);

        // Parked core, pending fetch survives cpu_on drop, then HALT.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(1'b0, c[0]);
            chk("parked req", mem_req, 1'b0);
        end
        @(negedge clk); drive(1'b1, 1'b0);
        chk("first fetch req", mem_req, 1'b1);
        chk("first fetch addr", mem_addr, RST_PC);
        chk("first fetch we", mem_we, 1'b0);
        @(negedge clk); drive(1'b0, 1'b0);
        chk("pending fetch held", mem_req, 1'b1);
        @(negedge clk); drive(1'b0, 1'b1);
        chk("pending fetch done", mem_req, 1'b1);
        @(negedge clk); drive(1'b0, 1'b1);
        chk("decode req", mem_req, 1'b0);
        chk("decode pc", pc, 8'h01);
        @(negedge clk); drive(1'b1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); drive(1'b1, 1'b1);
            chk("halt halted", halted, 1'b1);
            chk("halt req", mem_req, 1'b0);
        end
        chk("halt pc", pc, 8'h01);
        do_reset();
        #1;
        chk("unhalt", halted, 1'b0);

        // LDI/LDI/ADD/OUT
        clear_mem();
        tb_mem[0] = enc_i(4, 1, 5);
        tb_mem[1] = enc_i(4, 2, 7);
        tb_mem[2] = enc(0, 3, 1, 2);
        tb_mem[3] = enc(9, 0, 3, 0);
        do_reset();
        run_program("add", 4);
        chk("add out", out_r, 16'h000C);
        chk("add flags", flags, 4'b0000);

        // Overflow, SUB equal, AND, OR flags
        clear_mem();
        tb_mem[0] = enc_i(4, 4, 8'h80);
        tb_mem[1] = enc(5, 1, 4, 0);
        tb_mem[2] = enc_i(4, 2, 1);
        tb_mem[3] = enc(0, 3, 1, 2);
        tb_mem[4] = enc(9, 0, 3, 0);
        tb_mem[5] = enc(1, 5, 2, 2);
        tb_mem[6] = enc(2, 6, 1, 3);
        tb_mem[7] = enc(3, 7, 1, 3);
        tb_mem[8'h80] = 16'h7FFF;
        do_reset();
        run_program("ovf", 5);
        chk("ovf out", out_r, 16'h8000);
        chk("ovf flags", flags, 4'b1001);
        run_program("subz", 1);
        chk("subz flags", flags, 4'b0110);
        run_program("and", 1);
        chk("and flags", flags, 4'b0100);
        run_program("or", 1);
        chk("or flags", flags, 4'b1000);

        // ST then LD with three wait cycles on each data access
        clear_mem();
        tb_mem[0] = enc_i(4, 1, 8'h40);
        tb_mem[1] = enc_i(4, 2, 8'hAB);
        tb_mem[2] = enc(6, 0, 1, 2);
        tb_mem[3] = enc(5, 3, 1, 0);
        tb_mem[4] = enc(9, 0, 3, 0);
        do_reset();
        set_rdy_all(1'b1);
        rdy_arr[9] = 0; rdy_arr[10] = 0; rdy_arr[11] = 0;
        rdy_arr[16] = 0; rdy_arr[17] = 0; rdy_arr[18] = 0;
        run_program("stld", 5);
        chk("stld mem", tb_mem[8'h40], 16'h00AB);
        chk("stld out", out_r, 16'h00AB);
        set_rdy_all(1'b1);

        // pc wrap and BZ backwards
        clear_mem();
        tb_mem[0] = enc_i(4, 1, 8'hFF);
        tb_mem[1] = enc(7, 0, 1, 0);
        tb_mem[8'hFF] = enc(4'hA, 0, 0, 0);
        do_reset();
        run_program("wrap", 3);
        chk("wrap pc", pc, 8'h00);
        clear_mem();
        tb_mem[0] = enc(1, 0, 0, 0);
        tb_mem[1] = enc_i(4, 1, 8'h10);
        tb_mem[2] = enc(7, 0, 1, 0);
        tb_mem[8'h10] = enc_i(8, 0, 8'h80);
        do_reset();
        run_program("bz", 4);
        chk("bz pc", pc, 8'h91);

        // Reset during a stalled store
        clear_mem();
        tb_mem[0] = enc_i(4, 1, 8'h55);
        tb_mem[1] = enc_i(4, 2, 8'h30);
        tb_mem[2] = enc(6, 0, 2, 1);
        tb_mem[8'h30] = 16'h1234;
        do_reset();
        run_program("rstmem pre", 2);
        drive(1'b1, 1'b1);
        @(negedge clk); drive(1'b0, 1'b1);
        @(negedge clk); drive(1'b0, 1'b1);
        @(negedge clk); drive(1'b0, 1'b0);
        chk("rstmem req", mem_req, 1'b1);
        chk("rstmem we", mem_we, 1'b1);
        chk("rstmem addr", mem_addr, 8'h30);
        chk("rstmem wdata", mem_wdata, 16'h0055);
        @(negedge clk); rst = 1'b1; drive(1'b0, 1'b0);
        @(negedge clk); drive(1'b1, 1'b1);
        chk("rstmem req after", mem_req, 1'b0);
        chk("rstmem pc after", pc, RST_PC);
        @(negedge clk); rst = 1'b0;
        chk("rstmem no write", tb_mem[8'h30], 16'h1234);
        tb_mem[0] = enc(9, 0, 1, 0);
        tb_mem[1] = enc(9, 0, 2, 0);
        model_reset();
        run_program("rstmem regs", 2);

        // Random programs with random memory stalls
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 256; i++)
                tb_mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
            for (int i = 0; i < RDY_LEN; i++) rdy_arr[i] = ($urandom_range(0, 3) != 0);
            do_reset();
            run_program($sformatf("rand%0d", round), 40);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
